// File: rtl/jstk_spi_responder.sv
// SPI mode-0 responder emulating a PmodJSTK: returns a 5-byte joystick report and
// accepts an LED command in the first byte of each 40-bit frame.
`timescale 1ns/1ps
module jstk_spi_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       board_clk,
  input  logic       reset,
  input  logic       sclk,
  input  logic       ss_n,
  input  logic       mosi,
  output logic       miso,
  input  logic [9:0] x_pos,
  input  logic [9:0] y_pos,
  input  logic [2:0] buttons,
  output logic [1:0] led,
  output logic       busy,
  output logic       frame_done,
  output logic       frame_abort
);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, HOLD = 2'd2} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
  logic sclk_d, ss_d;
  logic sclk_s, ss_s, mosi_s;
  logic sclk_rise, sclk_fall, ss_rise, ss_fall;

  state_t      state, state_n;
  logic [39:0] tx, tx_n;
  logic [7:0]  rx, rx_n;
  logic [5:0]  bit_cnt, bit_cnt_n;
  logic        miso_n, done_n, abort_n;
  logic [1:0]  led_n;
  logic [39:0] tx_word;
  logic [7:0]  rx_shift;
  logic [5:0]  cnt_inc;

  // ss_n flops reset high so a reset never fabricates a select edge on its own.
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      sclk_sync <= '0;
      ss_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      ss_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      ss_d      <= ss_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign ss_s      = ss_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign ss_rise   = ss_s & ~ss_d;
  assign ss_fall   = ~ss_s & ss_d;

  assign tx_word  = {x_pos[7:0], 6'b0, x_pos[9:8], y_pos[7:0], 6'b0, y_pos[9:8], 5'b0, buttons};
  assign rx_shift = {rx[6:0], mosi_s};
  assign cnt_inc  = bit_cnt + 6'd1;

  always_comb begin
    state_n   = state;
    tx_n      = tx;
    rx_n      = rx;
    bit_cnt_n = bit_cnt;
    miso_n    = miso;
    led_n     = led;
    done_n    = 1'b0;
    abort_n   = 1'b0;
    case (state)
      IDLE: begin
        miso_n = 1'b0;
        if (ss_fall) begin
          tx_n      = tx_word;
          bit_cnt_n = 6'd0;
          miso_n    = tx_word[39];
          state_n   = SHIFT;
        end
      end
      SHIFT: begin
        // Select release outranks any sclk edge seen in the same cycle.
        if (ss_rise) begin
          state_n = IDLE;
          miso_n  = 1'b0;
          done_n  = (bit_cnt == 6'd40);
          abort_n = (bit_cnt != 6'd40);
        end else if (sclk_rise) begin
          rx_n      = rx_shift;
          bit_cnt_n = cnt_inc;
          if (cnt_inc == 6'd8 && rx_shift[7:2] == 6'b100000)
            led_n = rx_shift[1:0];
          if (cnt_inc == 6'd40) begin
            state_n = HOLD;
            miso_n  = 1'b0;
          end
        end else if (sclk_fall) begin
          tx_n   = {tx[38:0], 1'b0};
          miso_n = tx[38];
        end
      end
      HOLD: begin
        miso_n = 1'b0;
        if (ss_rise) begin
          state_n = IDLE;
          done_n  = (bit_cnt == 6'd40);
          abort_n = (bit_cnt != 6'd40);
        end
      end
      default: begin
        state_n = IDLE;
        miso_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      tx          <= '0;
      rx          <= '0;
      bit_cnt     <= '0;
      miso        <= 1'b0;
      led         <= 2'b00;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      state       <= state_n;
      tx          <= tx_n;
      rx          <= rx_n;
      bit_cnt     <= bit_cnt_n;
      miso        <= miso_n;
      led         <= led_n;
      frame_done  <= done_n;
      frame_abort <= abort_n;
    end
  end

  assign busy = (state == SHIFT) || (state == HOLD);

endmodule
